// File: rtl/mig_rw_burst_scheduler_if.sv
// Command/done handshake bundle between the burst scheduler and the
// AW/W (write) and AR/R (read) channel engines.
interface mig_rw_burst_scheduler_if;
    logic        wr_cmd_valid;
    logic        wr_cmd_ready;
    logic [31:0] wr_cmd_addr;
    logic [7:0]  wr_cmd_len;
    logic        wr_done;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [31:0] rd_cmd_addr;
    logic [7:0]  rd_cmd_len;
    logic        rd_done;

    modport master (
        output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        input  wr_cmd_ready, wr_done,
        output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        input  rd_cmd_ready, rd_done
    );

    modport slave (
        input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        output wr_cmd_ready, wr_done,
        input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        output rd_cmd_ready, rd_done
    );
endinterface

// File: rtl/mig_rw_burst_scheduler.sv
// DDR3 ring-buffer burst scheduler in front of the MIG AXI port.
// Define MIG_RW_SCHED_STATS_EN to add wr_burst_cnt/rd_burst_cnt outputs.
module mig_rw_burst_scheduler #(
    parameter int unsigned Max_Burst_Len  = 16,
    parameter int unsigned RW_Delay_Value = 64,
    parameter logic [31:0] Base_Address   = 32'h0000_0000,
    parameter int unsigned Memory_Size    = 1024,
    parameter int unsigned MIG_Port_Size  = 128
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        soft_resetn,
    input  logic [15:0] in_fifo_count,
    input  logic [15:0] out_fifo_free,
    mig_rw_burst_scheduler_if.master cmd,
    output logic [31:0] mem_count,
    output logic        busy
`ifdef MIG_RW_SCHED_STATS_EN
    ,
    output logic [31:0] wr_burst_cnt,
    output logic [31:0] rd_burst_cnt
`endif
);

    localparam int unsigned BYTES  = MIG_Port_Size / 8;
    localparam int unsigned BSHIFT = $clog2(BYTES);
    localparam int unsigned W4K    = 4096 / BYTES;

    localparam logic [31:0] MEM     = 32'(Memory_Size);
    localparam logic [31:0] MAXB    = 32'(Max_Burst_Len);
    localparam logic [31:0] HOLDMAX = 32'(RW_Delay_Value);
    localparam logic [31:0] W4KV    = 32'(W4K);
    localparam logic [31:0] W4KM    = 32'(W4K - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    state_t      state_q;
    logic        last_wr_q;
    logic [31:0] hold_q;
    logic [31:0] wp_q;
    logic [31:0] rp_q;
    logic [31:0] mem_q;
    logic [8:0]  beats_q;
    logic        busy_q;

    logic        wr_valid_q;
    logic [31:0] wr_addr_q;
    logic [7:0]  wr_len_q;
    logic        rd_valid_q;
    logic [31:0] rd_addr_q;
    logic [7:0]  rd_len_q;

`ifdef MIG_RW_SCHED_STATS_EN
    logic [31:0] wr_cnt_q;
    logic [31:0] rd_cnt_q;
`endif

    function automatic logic [31:0] min2(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a < b) ? a : b;
    endfunction

    // Room is the ring headroom (write) or fill (read); the last term
    // stops the burst at the next 4 KB page, Base_Address being aligned.
    function automatic logic [31:0] burst_beats(
        input logic [31:0] avail,
        input logic [31:0] room,
        input logic [31:0] ptr
    );
        logic [31:0] n;
        n = min2(MAXB, avail);
        n = min2(n, room);
        n = min2(n, MEM - ptr);
        n = min2(n, W4KV - (ptr & W4KM));
        return n;
    endfunction

    logic        wr_elig;
    logic        rd_elig;
    logic        go_wr;
    logic        go_rd;
    logic [31:0] wr_beats_d;
    logic [31:0] rd_beats_d;
    logic [31:0] hold_d;
    logic [31:0] beats32;
    logic [31:0] wp_adv;
    logic [31:0] rp_adv;
    logic [31:0] wp_d;
    logic [31:0] rp_d;

    always_comb begin
        wr_elig    = (in_fifo_count != 16'd0) && (mem_q < MEM);
        rd_elig    = (mem_q != 32'd0) && (out_fifo_free != 16'd0);
        wr_beats_d = burst_beats(32'(in_fifo_count), MEM - mem_q, wp_q);
        rd_beats_d = burst_beats(32'(out_fifo_free), mem_q, rp_q);
        go_wr      = 1'b0;
        go_rd      = 1'b0;
        if ((state_q == IDLE) && soft_resetn) begin
            if (wr_elig && rd_elig) begin
                if (hold_q < HOLDMAX) begin
                    go_wr = last_wr_q;
                    go_rd = !last_wr_q;
                end else begin
                    go_wr = !last_wr_q;
                    go_rd = last_wr_q;
                end
            end else begin
                go_wr = wr_elig;
                go_rd = rd_elig;
            end
        end
        hold_d = (hold_q < HOLDMAX) ? hold_q + 32'd1 : hold_q;
        if ((go_wr && !last_wr_q) || (go_rd && last_wr_q)) begin
            hold_d = '0;
        end
        beats32 = 32'(beats_q);
        wp_adv  = wp_q + beats32;
        rp_adv  = rp_q + beats32;
        wp_d    = (wp_adv == MEM) ? '0 : wp_adv;
        rp_d    = (rp_adv == MEM) ? '0 : rp_adv;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_wr_q  <= 1'b0;
            hold_q     <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            mem_q      <= '0;
            beats_q    <= '0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
`ifdef MIG_RW_SCHED_STATS_EN
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
`endif
        end else begin
            hold_q <= hold_d;
            case (state_q)
                IDLE: begin
                    if (!soft_resetn) begin
                        wp_q     <= '0;
                        rp_q     <= '0;
                        mem_q    <= '0;
                        hold_q   <= '0;
`ifdef MIG_RW_SCHED_STATS_EN
                        wr_cnt_q <= '0;
                        rd_cnt_q <= '0;
`endif
                    end else if (go_wr) begin
                        state_q    <= WR_ISSUE;
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= Base_Address + (wp_q << BSHIFT);
                        wr_len_q   <= 8'(wr_beats_d - 32'd1);
                        beats_q    <= 9'(wr_beats_d);
                        last_wr_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (go_rd) begin
                        state_q    <= RD_ISSUE;
                        rd_valid_q <= 1'b1;
                        rd_addr_q  <= Base_Address + (rp_q << BSHIFT);
                        rd_len_q   <= 8'(rd_beats_d - 32'd1);
                        beats_q    <= 9'(rd_beats_d);
                        last_wr_q  <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                WR_ISSUE: begin
                    if (cmd.wr_cmd_ready) begin
                        wr_valid_q <= 1'b0;
                        state_q    <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (cmd.wr_done) begin
                        mem_q    <= mem_q + beats32;
                        wp_q     <= wp_d;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
`ifdef MIG_RW_SCHED_STATS_EN
                        wr_cnt_q <= wr_cnt_q + 32'd1;
`endif
                    end
                end
                RD_ISSUE: begin
                    if (cmd.rd_cmd_ready) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cmd.rd_done) begin
                        mem_q    <= mem_q - beats32;
                        rp_q     <= rp_d;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
`ifdef MIG_RW_SCHED_STATS_EN
                        rd_cnt_q <= rd_cnt_q + 32'd1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd.wr_cmd_valid = wr_valid_q;
    assign cmd.wr_cmd_addr  = wr_addr_q;
    assign cmd.wr_cmd_len   = wr_len_q;
    assign cmd.rd_cmd_valid = rd_valid_q;
    assign cmd.rd_cmd_addr  = rd_addr_q;
    assign cmd.rd_cmd_len   = rd_len_q;
    assign mem_count        = mem_q;
    assign busy             = busy_q;

`ifdef MIG_RW_SCHED_STATS_EN
    assign wr_burst_cnt = wr_cnt_q;
    assign rd_burst_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mig_rw_burst_scheduler.sv
// Directed bench for mig_rw_burst_scheduler with a command scoreboard
// and a simple channel-engine responder.
module tb_mig_rw_burst_scheduler;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        soft_resetn = 1'b1;
    logic [15:0] in_fifo_count = '0;
    logic [15:0] out_fifo_free = '0;
    logic [31:0] mem_count;
    logic        busy;
`ifdef MIG_RW_SCHED_STATS_EN
    logic [31:0] wr_burst_cnt;
    logic [31:0] rd_burst_cnt;
`endif

    mig_rw_burst_scheduler_if bus ();

    mig_rw_burst_scheduler dut (
        .aclk          (aclk),
        .reset         (reset),
        .soft_resetn   (soft_resetn),
        .in_fifo_count (in_fifo_count),
        .out_fifo_free (out_fifo_free),
        .cmd           (bus),
        .mem_count     (mem_count),
        .busy          (busy)
`ifdef MIG_RW_SCHED_STATS_EN
        ,
        .wr_burst_cnt  (wr_burst_cnt),
        .rd_burst_cnt  (rd_burst_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_mem = 0;
    int   pm_mem = 0;
    int   pm_wp = 0;
    int   pm_rp = 0;
    int   pm_in = 0;
    int   pm_out = 0;
    bit   pm_last_wr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int minb(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int beats(input int avail, input int room,
                                 input int ptr);
        return minb(minb(minb(16, avail), room),
                    minb(1024 - ptr, 256 - (ptr % 256)));
    endfunction

    task automatic pushx(input bit w, input int addr, input int len);
        sbq.push_back('{w, 32'(addr), 8'(len)});
        pm_last_wr = w;
        if (w) begin
            pm_mem += len + 1;
            pm_in  -= len + 1;
            pm_wp   = (pm_wp + len + 1) % 1024;
        end else begin
            pm_mem -= len + 1;
            pm_out -= len + 1;
            pm_rp   = (pm_rp + len + 1) % 1024;
        end
    endtask

    // Predicts a run of back-to-back bursts; the responder below gives
    // a fixed three-cycle spacing between successive command valids.
    task automatic plan(input int n);
        int t;
        int c0;
        int b;
        bit we;
        bit re;
        bit w;
        t  = 0;
        c0 = -1000;
        for (int k = 0; k < n; k++) begin
            we = (pm_in > 0) && (pm_mem < 1024);
            re = (pm_mem > 0) && (pm_out > 0);
            if (!we && !re) break;
            if (we && re) w = ((t - 1 - c0) < 64) ? pm_last_wr : !pm_last_wr;
            else w = we;
            if (w != pm_last_wr) c0 = t;
            if (w) b = beats(pm_in, 1024 - pm_mem, pm_wp);
            else b = beats(pm_out, pm_mem, pm_rp);
            pushx(w, (w ? pm_wp : pm_rp) * 16, b - 1);
            t += 3;
        end
    endtask

    task automatic serve(output int lat, input bit soft_mid);
        exp_t e;
        bit   w;
        int   b;
        lat = 0;
        while (!bus.wr_cmd_valid && !bus.rd_cmd_valid && lat < 300) begin
            @(negedge aclk);
            lat++;
        end
        chk("cmd_timeout", 32'(lat < 300), 32'd1);
        if (lat >= 300) return;
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty: observed=command expected=none");
        end
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        w = bus.wr_cmd_valid;
        chk("dir", 32'(w), 32'(e.wr));
        chk("both_valid", 32'(bus.wr_cmd_valid & bus.rd_cmd_valid), 32'd0);
        chk("addr", w ? bus.wr_cmd_addr : bus.rd_cmd_addr, e.addr);
        chk("len", 32'(w ? bus.wr_cmd_len : bus.rd_cmd_len), 32'(e.len));
        if (w) bus.wr_cmd_ready = 1'b1;
        else bus.rd_cmd_ready = 1'b1;
        @(negedge aclk);
        bus.wr_cmd_ready = 1'b0;
        bus.rd_cmd_ready = 1'b0;
        chk("valid_drop", 32'(bus.wr_cmd_valid | bus.rd_cmd_valid), 32'd0);
        if (soft_mid) soft_resetn = 1'b0;
        if (w) bus.wr_done = 1'b1;
        else bus.rd_done = 1'b1;
        @(negedge aclk);
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        b = int'(e.len) + 1;
        if (e.wr) begin
            exp_mem += b;
            in_fifo_count -= 16'(b);
        end else begin
            exp_mem -= b;
            out_fifo_free -= 16'(b);
        end
        chk("mem_count", mem_count, exp_mem);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int b;
        int quiet;
        bus.wr_cmd_ready = 1'b0;
        bus.rd_cmd_ready = 1'b0;
        bus.wr_done      = 1'b0;
        bus.rd_done      = 1'b0;
        repeat (3) @(negedge aclk);
        reset = 1'b0;
        chk("rst_wr_valid", 32'(bus.wr_cmd_valid), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_cmd_valid), 32'd0);
        chk("rst_wr_addr", bus.wr_cmd_addr, 32'd0);
        chk("rst_rd_len", 32'(bus.rd_cmd_len), 32'd0);
        chk("rst_mem", mem_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        in_fifo_count = 16'd40;
        pm_in = 40;
        pushx(1, 32'h000, 15);
        pushx(1, 32'h100, 15);
        pushx(1, 32'h200, 7);
        serve(lat, 0);
        chk("decision_lat", lat, 32'd1);
        serve(lat, 0);
        serve(lat, 0);
        chk("fill40_mem", mem_count, 32'd40);
        @(negedge aclk);
        chk("fill40_idle", 32'(busy), 32'd0);

        in_fifo_count = 16'd980;
        pm_in = 980;
        plan(200);
        while (sbq.size() > 0) serve(lat, 0);
        chk("fill1020_mem", mem_count, 32'd1020);

        out_fifo_free = 16'd20;
        pm_out = 20;
        plan(10);
        while (sbq.size() > 0) serve(lat, 0);

        in_fifo_count = 16'd16;
        pm_in = 16;
        pushx(1, 1020 * 16, 3);
        pushx(1, 32'h000, 11);
        serve(lat, 0);
        serve(lat, 0);
        in_fifo_count = 16'd8;
        pm_in = 8;
        pushx(1, 32'h0C0, 7);
        serve(lat, 0);
        chk("full_mem", mem_count, 32'd1024);

        in_fifo_count = 16'd100;
        pm_in = 100;
        out_fifo_free = 16'd8;
        pm_out = 8;
        pushx(0, 32'h140, 7);
        pushx(1, 32'h140, 7);
        @(negedge aclk);
        chk("full_no_wr", 32'(bus.wr_cmd_valid), 32'd0);
        chk("full_rd", 32'(bus.rd_cmd_valid), 32'd1);
        serve(lat, 0);
        serve(lat, 0);

        repeat (70) @(negedge aclk);
        in_fifo_count = 16'd2000;
        pm_in = 2000;
        out_fifo_free = 16'd2000;
        pm_out = 2000;
        plan(60);
        while (sbq.size() > 0) serve(lat, 0);

        in_fifo_count = 16'd0;
        pm_in = 0;
        out_fifo_free = 16'd4;
        pm_out = 4;
        b = beats(4, pm_mem, pm_rp);
        pushx(0, pm_rp * 16, b - 1);
        serve(lat, 1);
        @(negedge aclk);
        chk("soft_clear_mem", mem_count, 32'd0);
`ifdef MIG_RW_SCHED_STATS_EN
        chk("soft_clear_wrcnt", wr_burst_cnt, 32'd0);
`endif
        in_fifo_count = 16'd10;
        out_fifo_free = 16'd10;
        quiet = 0;
        repeat (10) begin
            @(negedge aclk);
            if (bus.wr_cmd_valid | bus.rd_cmd_valid | busy) quiet++;
        end
        chk("soft_hold_quiet", quiet, 32'd0);
        pm_mem = 0;
        pm_wp = 0;
        pm_rp = 0;
        exp_mem = 0;
        pm_in = 10;
        out_fifo_free = 16'd0;
        pm_out = 0;
        pushx(1, 32'h000, 9);
        soft_resetn = 1'b1;
        serve(lat, 0);
        chk("soft_release_lat", lat, 32'd1);
        out_fifo_free = 16'd10;
        pm_out = 10;
        pushx(0, 32'h000, 9);
        serve(lat, 0);

        in_fifo_count = 16'd3;
        lat = 0;
        while (!bus.wr_cmd_valid && lat < 300) begin
            @(negedge aclk);
            lat++;
        end
        chk("rstw_timeout", 32'(lat < 300), 32'd1);
        chk("rstw_addr", bus.wr_cmd_addr, 32'h0A0);
        chk("rstw_len", 32'(bus.wr_cmd_len), 32'd2);
        bus.wr_cmd_ready = 1'b1;
        @(negedge aclk);
        bus.wr_cmd_ready = 1'b0;
        chk("rstw_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        in_fifo_count = 16'd0;
        @(negedge aclk);
        chk("rstw_wr_valid", 32'(bus.wr_cmd_valid), 32'd0);
        chk("rstw_addr0", bus.wr_cmd_addr, 32'd0);
        chk("rstw_len0", 32'(bus.wr_cmd_len), 32'd0);
        chk("rstw_mem0", mem_count, 32'd0);
        chk("rstw_busy0", 32'(busy), 32'd0);
        reset = 1'b0;
        bus.wr_done = 1'b1;
        @(negedge aclk);
        bus.wr_done = 1'b0;
        @(negedge aclk);
        chk("stray_done_mem", mem_count, 32'd0);
        chk("stray_done_busy", 32'(busy), 32'd0);
        chk("stray_done_valid", 32'(bus.wr_cmd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mig_rw_burst_scheduler.md
Name: mig_rw_burst_scheduler

Overview:
- Controller in front of the MIG AXI port of the MIG-based FIFO. It uses the DDR3 region as a ring buffer between the input AXIS FIFO and the output AXIS FIFO.
- Decides each cycle whether to issue a write burst, a read burst or nothing. Computes burst address and length, tracks ring pointers and DDR fill level.
- Feeds separate AW/W and AR/R channel engines through a simple command/done interface; one burst outstanding at a time.

Parameters:
- Max_Burst_Len, 16, maximum beats per burst (1..256); Max_Burst_Len*MIG_Port_Size/8 <= 4096
- RW_Delay_Value, 64, cycles a direction is held before yielding to the other eligible direction
- Base_Address, 32'h0000_0000, byte address of ring start; 4 KB aligned
- Memory_Size, 1024, ring size in MIG words
- MIG_Port_Size, 128, MIG data width in bits (power of 2, >= 32)

Ports:
- aclk  in  1  clock (MIG ui_clk)
- reset  in  1  synchronous, active-high reset
- soft_resetn  in  1  active-low pointer/count clear, taken only in IDLE
- in_fifo_count  in  16  words available in input FIFO
- out_fifo_free  in  16  free words in output FIFO
- wr_cmd_valid  out  1  write burst command valid
- wr_cmd_ready  in  1  write engine accepts command
- wr_cmd_addr  out  32  AWADDR for burst
- wr_cmd_len  out  8  AWLEN (beats-1)
- wr_done  in  1  one-cycle pulse on BVALID&BREADY of current burst
- rd_cmd_valid  out  1  read burst command valid
- rd_cmd_ready  in  1  read engine accepts command
- rd_cmd_addr  out  32  ARADDR for burst
- rd_cmd_len  out  8  ARLEN (beats-1)
- rd_done  in  1  one-cycle pulse on RLAST&RVALID&RREADY of current burst
- mem_count  out  32  words committed in DDR, 0..Memory_Size
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all valids 0, addr/len 0, mem_count 0, busy 0. Write pointer wp and read pointer rp = 0 (word index). State IDLE, last_dir = READ (so write is tried first), hold counter 0.
- Word-to-byte address: addr = Base_Address + index*(MIG_Port_Size/8).
- Write eligible: in_fifo_count>0 and mem_count<Memory_Size.
- Read eligible: mem_count>0 and out_fifo_free>0.
- Write beats: min(Max_Burst_Len, in_fifo_count, Memory_Size-mem_count, Memory_Size-wp, words to next 4 KB boundary).
- Read beats: the same, using mem_count, out_fifo_free and rp in place of the write terms.
- A burst never wraps the ring and never crosses 4 KB.
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
- IDLE direction choice:
  - Only one direction eligible: go to it.
  - Both eligible: repeat last_dir while hold counter < RW_Delay_Value, else switch to the other direction.
  - Neither eligible: stay in IDLE.
  - Hold counter counts cycles since the last direction change; it saturates and clears on a change.
- Addr/len are latched on the IDLE->ISSUE transition and stay stable while valid is high.
- WR_ISSUE: wr_cmd_valid=1 until wr_cmd_ready is sampled high, then WR_WAIT. RD_ISSUE/RD_WAIT mirror this.
- Decision latency: an eligible condition in IDLE gives valid high on the next cycle.
- WR_WAIT, on wr_done:
  - mem_count += beats.
  - wp += beats; if wp == Memory_Size, wp = 0.
  - Return to IDLE.
- RD_WAIT, on rd_done: mem_count -= beats, rp advances with the same wrap rule, return to IDLE.
- A burst returns to IDLE at the earliest one cycle after the handshake. A done pulse in IDLE or ISSUE is ignored.
- Full ring (mem_count==Memory_Size): writes are ineligible and reads proceed.
- Empty ring (mem_count==0): reads are ineligible.
- reset mid-burst: immediate return to reset state; the in-flight burst is abandoned.
- soft_resetn=0: any in-flight burst completes first. In IDLE, wp/rp/mem_count/hold are cleared and no command issues while it stays low.

Optional Feature:
- Macro MIG_RW_SCHED_STATS_EN.
- Defined: adds outputs wr_burst_cnt[31:0] and rd_burst_cnt[31:0]. Each increments on its done pulse, wraps at 2^32, and clears on reset or soft clear.
- Undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- After reset: in_fifo_count=40, out_fifo_free=0, Memory_Size=1024 -> write bursts of len 15,15,7 at addr 0x0, 0x100, 0x200; mem_count=40.
- Ring wrap: wp=1020 with in_fifo_count=16 -> burst len 3 (4 beats) at Base+1020*16, then wp=0 and the next burst starts at Base_Address.
- Full ring: mem_count=1024 with in_fifo_count=100, out_fifo_free=8 -> no wr_cmd_valid; read len 7, mem_count becomes 1016.
- Arbitration, RW_Delay_Value=64 with both directions continuously eligible -> writes continue until the hold counter reaches 64, then a read issues; directions alternate thereafter.
- Reset in WR_WAIT before wr_done -> next cycle all outputs 0, mem_count 0, state IDLE; a later stray wr_done has no effect.
- soft_resetn=0 asserted in RD_WAIT -> rd_done still decrements mem_count, then all counts clear in IDLE; no command issues until soft_resetn=1.
